// File: rtl/alu_div_pkg.sv
// Shared constants and state encoding for the ALU_16 sequential signed divider.
package alu_div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_MOST_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0] rem_i,
    input  logic           bit_i,
    input  logic [WIDTH:0] dvs_i,
    output logic [WIDTH:0] rem_o,
    output logic           q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // The remainder stays below the divisor magnitude, so the shifted value
    // never reaches the extra top bit and that bit acts as the trial's sign.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, dvs_i};
        q_o     = ~trial[WIDTH+1];
        rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: sign/magnitude capture, WIDTH restoring steps,
// then a fix-up cycle that applies signs, sets status flags and pulses done.
module seq_signed_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    // Negating -2^(WIDTH-1) yields the same bit pattern, which read as
    // unsigned is exactly the magnitude 2^(WIDTH-1).
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dz_d          = dz_q;
        ovf_d         = ovf_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvs_d     = {1'b0, dvs_mag};
                    neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d = dividend[WIDTH-1];
                    dz_d      = (divisor == '0);
                    ovf_d     = (dividend == MOST_NEG) && (divisor == '1);
                    if (divisor == '0) begin
                        // The raw dividend rides in the quotient shifter so
                        // FIX can return it as the remainder.
                        quo_d   = dividend;
                        state_d = FIX;
                    end else begin
                        quo_d   = dvd_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                div_by_zero_d = dz_q;
                overflow_d    = ovf_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dz_q          <= 1'b0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dz_q          <= dz_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule
